jogador_automatico: RTL and testbench
=====================================

# jogador_automatico

Hardware auto-player for the memory game datapath: it drives the game's `iniciar` and `chaves` inputs with a fixed one-hot play sequence and watches `pronto`/`acertou`/`errou`. It then reports whether the game ended the way the run requested. It sits beside `circuito_exp4` on the FPGA for self-test and demo runs, replacing the human player.

## Interface
- `START_CYCLES`, default 5: cycles that `iniciar` is held high.
- `HOLD_CYCLES`, default 10: cycles each play is held on `chaves`.
- `GAP_CYCLES`, default 10: cycles with `chaves`=0 after start and after each play.
- `NUM_JOGADAS`, default 16: plays in a full run, range 1..16.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `executar` in 1: run request. Sampled only in OCIOSO or FIM.
- `injetar` in 1: request a wrong play. Captured with `executar`.
- `jogada_erro` in 4: index of the play to corrupt. Captured with `executar`.
- `pronto_jogo` in 1: game finished.
- `acertou_jogo` in 1: game result, correct.
- `errou_jogo` in 1: game result, wrong.
- `iniciar` out 1: start pulse to the game.
- `chaves` out 4: play value to the game.
- `ocupado` out 1: run in progress.
- `fim` out 1: run finished. Held until the next run or reset.
- `sucesso` out 1: the game outcome matched the expectation. Valid while `fim`=1.
- `jogadas_feitas` out 5: plays completed in the current run.
- `db_estado` out 4: state code.

## Operation
- All outputs are registered and decoded from state/counters (Moore).
- State codes:
  - OCIOSO=0
  - INICIA=1
  - ESPERA=2
  - APLICA=3
  - SOLTA=4
  - FIM=5
- Expected play k (0-based) is `4'b0001 << (k mod 4)`: 0001, 0010, 0100, 1000, 0001, …
- Injected play:
  - Injection is effective only when `injetar`=1 and `jogada_erro` < NUM_JOGADAS.
  - If effective, play k=`jogada_erro` is the expected value rotated left by 1 (1000 → 0001, 0001 → 0010).
- State sequence:
  - OCIOSO --`executar`--> INICIA. Captures `injetar`/`jogada_erro`, clears `jogadas_feitas`, `fim`, `sucesso`.
  - INICIA: `iniciar`=1 for START_CYCLES, then ESPERA.
  - ESPERA: `chaves`=0 for GAP_CYCLES, then APLICA with k=0.
  - APLICA: `chaves`=play k for HOLD_CYCLES, then SOLTA. `jogadas_feitas` increments on exit.
  - SOLTA: `chaves`=0 for GAP_CYCLES, then the decision step below.
- Flags P/A/E:
  - Cleared on entry to APLICA.
  - Set by `pronto_jogo`/`acertou_jogo`/`errou_jogo` on any cycle of APLICA or SOLTA, including the final SOLTA cycle.
- Decision at end of SOLTA:
  - If P=1: go to FIM. `sucesso`=1 iff one of these holds:
    - injection effective, k=`jogada_erro`, E=1 and A=0;
    - injection not effective, k=NUM_JOGADAS-1, A=1 and E=0.
  - Otherwise `sucesso`=0 (early or wrong finish).
  - Else if k=NUM_JOGADAS-1, or injection effective and k=`jogada_erro`: go to FIM with `sucesso`=0 (timeout).
  - Else k++ and go to APLICA.
- FIM:
  - `fim`=1, `ocupado`=0, `chaves`=0.
  - `executar` restarts at INICIA.
- `ocupado`=1 in INICIA/ESPERA/APLICA/SOLTA. `executar` is ignored there.
- Reset values: state OCIOSO, and every output 0 (`iniciar`, `chaves`, `ocupado`, `fim`, `sucesso`, `jogadas_feitas`, `db_estado`).

## Timing
- `executar` high at edge t: INICIA from edge t, so `iniciar`=1 during cycles t+1..t+START_CYCLES.
- The first play appears on `chaves` START_CYCLES+GAP_CYCLES cycles after `iniciar` rises.
- Each play occupies exactly HOLD_CYCLES+GAP_CYCLES cycles.
- `fim` rises START_CYCLES + GAP_CYCLES + n·(HOLD_CYCLES+GAP_CYCLES) cycles after `iniciar` rises, where n is plays made. Defaults with n=4: 95.
- `chaves` never changes in the same cycle as `iniciar`. `iniciar` and `chaves`≠0 never overlap.
- Game responses arriving in OCIOSO, INICIA or ESPERA are ignored.
- `reset` asserted in any state: OCIOSO with all outputs 0 at the next edge; no partial play is left on `chaves`.
- `reset` and `executar` in the same cycle: reset wins.

## Test plan
- **Reset:** assert `reset` 1 cycle from an arbitrary state → all outputs 0, `db_estado`=0; `executar` held in the reset cycle has no effect.
- **Full success (NUM_JOGADAS=4, defaults otherwise), `injetar`=0:**
  - `iniciar` high 5 cycles.
  - `chaves` 0001/0010/0100/1000, 10 cycles each with 10-cycle gaps.
  - Game model pulses `pronto`+`acertou` in 4th SOLTA → `fim`=1 at cycle 95, `sucesso`=1, `jogadas_feitas`=4.
- **Injected error, `injetar`=1, `jogada_erro`=3:**
  - 4th play is 0001.
  - Model pulses `pronto`+`errou` → `sucesso`=1, `jogadas_feitas`=4.
- **Unexpected error, `injetar`=0:** model pulses `pronto`+`errou` during play 1 → `fim`=1, `sucesso`=0, `jogadas_feitas`=2, no third play driven.
- **Timeout:** model never asserts `pronto` → `fim`=1 at cycle 95, `sucesso`=0, `jogadas_feitas`=4.
- **Restart and reset mid-run:**
  - `executar` pulsed during APLICA is ignored; no counter change.
  - `reset` in play 2 → outputs 0 next edge.
  - `executar` from FIM restarts with `jogadas_feitas`=0 and `fim`=0.

Source files
------------

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: drives a fixed one-hot play sequence
// and reports whether the game ended the way the run requested.
module jogador_automatico #(
    parameter int unsigned START_CYCLES = 5,
    parameter int unsigned HOLD_CYCLES  = 10,
    parameter int unsigned GAP_CYCLES   = 10,
    parameter int unsigned NUM_JOGADAS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       executar,
    input  logic       injetar,
    input  logic [3:0] jogada_erro,
    input  logic       pronto_jogo,
    input  logic       acertou_jogo,
    input  logic       errou_jogo,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       ocupado,
    output logic       fim,
    output logic       sucesso,
    output logic [4:0] jogadas_feitas,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        StOcioso = 3'd0,
        StInicia = 3'd1,
        StEspera = 3'd2,
        StAplica = 3'd3,
        StSolta  = 3'd4,
        StFim    = 3'd5
    } state_t;

    localparam logic [15:0] StartLast = 16'(START_CYCLES - 1);
    localparam logic [15:0] HoldLast  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GapLast   = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  LastK     = 4'(NUM_JOGADAS - 1);
    localparam logic [4:0]  NumJ      = 5'(NUM_JOGADAS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  k_q, k_d, err_q, err_d;
    logic [4:0]  feitas_q, feitas_d;
    logic        inj_q, inj_d, suc_q, suc_d;
    logic        p_q, p_d, a_q, a_d, e_q, e_d;
    logic        iniciar_q, iniciar_d, ocupado_q, ocupado_d, fim_q, fim_d;
    logic [3:0]  chaves_q, chaves_d, estado_q, estado_d;
    logic        eff, at_err, last_k, p_now, a_now, e_now;
    logic [3:0]  esperado, jogada;

    assign eff    = inj_q && ({1'b0, err_q} < NumJ);
    assign at_err = eff && (k_q == err_q);
    assign last_k = (k_q == LastK);
    // Responses on the final SOLTA cycle still count toward the decision.
    assign p_now  = p_q | pronto_jogo;
    assign a_now  = a_q | acertou_jogo;
    assign e_now  = e_q | errou_jogo;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StOcioso;
            cnt_q     <= '0;
            k_q       <= '0;
            err_q     <= '0;
            feitas_q  <= '0;
            inj_q     <= 1'b0;
            suc_q     <= 1'b0;
            p_q       <= 1'b0;
            a_q       <= 1'b0;
            e_q       <= 1'b0;
            iniciar_q <= 1'b0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
            chaves_q  <= '0;
            estado_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            err_q     <= err_d;
            feitas_q  <= feitas_d;
            inj_q     <= inj_d;
            suc_q     <= suc_d;
            p_q       <= p_d;
            a_q       <= a_d;
            e_q       <= e_d;
            iniciar_q <= iniciar_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
            chaves_q  <= chaves_d;
            estado_q  <= estado_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        err_d    = err_q;
        feitas_d = feitas_q;
        inj_d    = inj_q;
        suc_d    = suc_q;
        p_d      = p_q;
        a_d      = a_q;
        e_d      = e_q;
        unique case (state_q)
            StOcioso, StFim: begin
                if (executar) begin
                    state_d  = StInicia;
                    cnt_d    = '0;
                    k_d      = '0;
                    inj_d    = injetar;
                    err_d    = jogada_erro;
                    feitas_d = '0;
                    suc_d    = 1'b0;
                end
            end
            StInicia: begin
                if (cnt_q == StartLast) begin
                    state_d = StEspera;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StEspera: begin
                if (cnt_q == GapLast) begin
                    state_d = StAplica;
                    cnt_d   = '0;
                    k_d     = '0;
                    p_d     = 1'b0;
                    a_d     = 1'b0;
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StAplica: begin
                p_d = p_now;
                a_d = a_now;
                e_d = e_now;
                if (cnt_q == HoldLast) begin
                    state_d  = StSolta;
                    cnt_d    = '0;
                    feitas_d = feitas_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSolta: begin
                p_d = p_now;
                a_d = a_now;
                e_d = e_now;
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (p_now) begin
                        state_d = StFim;
                        suc_d   = (at_err && e_now && !a_now) ||
                                  (!eff && last_k && a_now && !e_now);
                    end else if (last_k || at_err) begin
                        state_d = StFim;
                        suc_d   = 1'b0;
                    end else begin
                        state_d = StAplica;
                        k_d     = k_q + 4'd1;
                        p_d     = 1'b0;
                        a_d     = 1'b0;
                        e_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StOcioso;
        endcase
    end

    // Outputs are decoded from next-state values so registered outputs line up with the state.
    always_comb begin
        esperado  = 4'b0001 << k_d[1:0];
        jogada    = (eff && (k_d == err_q)) ? {esperado[2:0], esperado[3]} : esperado;
        iniciar_d = (state_d == StInicia);
        chaves_d  = (state_d == StAplica) ? jogada : 4'd0;
        ocupado_d = (state_d == StInicia) || (state_d == StEspera) ||
                    (state_d == StAplica) || (state_d == StSolta);
        fim_d     = (state_d == StFim);
        estado_d  = {1'b0, state_d};
    end

    assign iniciar        = iniciar_q;
    assign chaves         = chaves_q;
    assign ocupado        = ocupado_q;
    assign fim            = fim_q;
    assign sucesso        = suc_q;
    assign jogadas_feitas = feitas_q;
    assign db_estado      = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a game model answers the plays and a monitor
// checks timed output events against a queue of expected events.
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset, executar, injetar;
    logic [3:0] jogada_erro;
    logic       pronto_jogo, acertou_jogo, errou_jogo;
    logic       iniciar, ocupado, fim, sucesso;
    logic [3:0] chaves, db_estado;
    logic [4:0] jogadas_feitas;

    always #5 clock = ~clock;

    jogador_automatico #(
        .START_CYCLES(5),
        .HOLD_CYCLES (10),
        .GAP_CYCLES  (10),
        .NUM_JOGADAS (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .executar      (executar),
        .injetar       (injetar),
        .jogada_erro   (jogada_erro),
        .pronto_jogo   (pronto_jogo),
        .acertou_jogo  (acertou_jogo),
        .errou_jogo    (errou_jogo),
        .iniciar       (iniciar),
        .chaves        (chaves),
        .ocupado       (ocupado),
        .fim           (fim),
        .sucesso       (sucesso),
        .jogadas_feitas(jogadas_feitas),
        .db_estado     (db_estado)
    );

    localparam int KIni = 0, KIniFall = 1, KPlay = 2, KRel = 3, KFim = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    logic       mute = 1'b1;
    logic       p_ini = 1'b0;
    logic       p_fim = 1'b0;
    logic [3:0] p_ch = 4'd0;

    int         mdl_mode = 0, mdl_tgt = 0, mdl_idx = 0, mdl_delay = 0, mdl_kind = 0;
    bit         mdl_noise = 1'b0;
    logic [3:0] mdl_prev = 4'd0;
    logic       mdl_pini = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            KIni:     return "iniciar_rise";
            KIniFall: return "iniciar_fall";
            KPlay:    return "play";
            KRel:     return "release";
            default:  return "fim_rise";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic got(input int kind, input int val, input int c);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s val %0d cyc %0d, required none",
                     kname(kind), val, c);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != c) begin
                errors++;
                $display("FAIL %s: got %s val %0d cyc %0d, required %s val %0d cyc %0d",
                         kname(e.kind), kname(kind), val, c, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Plays packed as {p3, p2, p1, p0}; event times relative to iniciar rising.
    task automatic expect_run(input int n, input logic [15:0] plays, input int suc);
        logic [3:0] p;
        push_ev(KIni, 0, 0);
        push_ev(KIniFall, 0, 5);
        for (int j = 0; j < n; j++) begin
            p = plays[4*j +: 4];
            push_ev(KPlay, int'(p), 15 + 20 * j);
            push_ev(KRel, j + 1, 25 + 20 * j);
        end
        push_ev(KFim, suc * 32 + n, 15 + 20 * n);
    endtask

    task automatic launch(input logic inj, input logic [3:0] err, input int mode,
                          input int tgt, input bit noise);
        mdl_mode    = mode;
        mdl_tgt     = tgt;
        mdl_noise   = noise;
        injetar     = inj;
        jogada_erro = err;
        executar    = 1'b1;
        @(posedge clock); #1;
        executar    = 1'b0;
        injetar     = 1'b0;
        jogada_erro = 4'd0;
    endtask

    task automatic wait_drain(input int settle);
        int i = 0;
        while (sb.size() != 0 && i < 400) begin
            @(posedge clock);
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d events pending, required 0", sb.size());
            sb.delete();
        end
        repeat (settle) @(posedge clock);
        #1;
    endtask

    task automatic chk_end(input string name, input int suc, input int n);
        chk({name, "_estado"}, int'(db_estado), 5);
        chk({name, "_sucesso"}, int'(sucesso), suc);
        chk({name, "_jogadas"}, int'(jogadas_feitas), n);
        chk({name, "_ocupado_chaves"}, int'({ocupado, chaves}), 0);
    endtask

    // Monitor: turns output edges into events and scores them.
    initial begin
        int v;
        forever begin
            @(negedge clock);
            if (!mute) begin
                if (iniciar && !p_ini) begin
                    t0 = cyc;
                    v  = int'({fim, sucesso, jogadas_feitas});
                    got(KIni, v, 0);
                end
                if (!iniciar && p_ini) got(KIniFall, 0, cyc - t0);
                if (chaves != 4'd0 && chaves != p_ch) got(KPlay, int'(chaves), cyc - t0);
                if (chaves == 4'd0 && p_ch != 4'd0) got(KRel, int'(jogadas_feitas), cyc - t0);
                if (fim && !p_fim) begin
                    v = int'({sucesso, jogadas_feitas});
                    got(KFim, v, cyc - t0);
                end
            end
            p_ini = iniciar;
            p_ch  = chaves;
            p_fim = fim;
            mute  = reset;
        end
    end

    // Game model: answers with a one-cycle pulse a few cycles after a chosen play edge.
    initial begin
        pronto_jogo  = 1'b0;
        acertou_jogo = 1'b0;
        errou_jogo   = 1'b0;
        forever begin
            @(negedge clock);
            pronto_jogo  = 1'b0;
            acertou_jogo = 1'b0;
            errou_jogo   = 1'b0;
            if (mdl_delay > 0) begin
                mdl_delay--;
                if (mdl_delay == 0) begin
                    pronto_jogo  = 1'b1;
                    acertou_jogo = (mdl_kind == 1);
                    errou_jogo   = (mdl_kind == 2);
                end
            end
            if (iniciar && !mdl_pini) mdl_idx = 0;
            if (!iniciar && mdl_pini && mdl_noise) begin
                mdl_delay = 3;
                mdl_kind  = 2;
            end
            if (chaves != 4'd0 && mdl_prev == 4'd0 && mdl_mode == 3 && mdl_idx == mdl_tgt) begin
                mdl_delay = 3;
                mdl_kind  = 2;
            end
            if (chaves == 4'd0 && mdl_prev != 4'd0) begin
                if ((mdl_mode == 1 || mdl_mode == 2) && mdl_idx == mdl_tgt) begin
                    mdl_delay = 3;
                    mdl_kind  = mdl_mode;
                end
                mdl_idx++;
            end
            mdl_prev = chaves;
            mdl_pini = iniciar;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        executar    = 1'b1;
        injetar     = 1'b0;
        jogada_erro = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        executar = 1'b0;
        chk("reset_outputs",
            int'({iniciar, chaves, ocupado, fim, sucesso, jogadas_feitas, db_estado}), 0);
        @(posedge clock); #1;
        chk("reset_exec_ignored", int'(db_estado), 0);

        // Full success, with a stray response during ESPERA that must be ignored.
        expect_run(4, 16'h8421, 1);
        launch(1'b0, 4'd0, 1, 3, 1'b1);
        wait_drain(20);
        chk_end("success", 1, 4);

        // Injected error on play 3, restarted from FIM.
        expect_run(4, 16'h1421, 1);
        launch(1'b1, 4'd3, 2, 3, 1'b0);
        wait_drain(20);
        chk_end("injected", 1, 4);

        // Unexpected error during play 1 ends the run after two plays.
        expect_run(2, 16'h0021, 0);
        launch(1'b0, 4'd0, 3, 1, 1'b0);
        wait_drain(20);
        chk_end("unexpected_err", 0, 2);

        // jogada_erro equal to NUM_JOGADAS: injection not effective.
        expect_run(4, 16'h8421, 1);
        launch(1'b1, 4'd4, 1, 3, 1'b0);
        wait_drain(20);
        chk_end("inject_oob", 1, 4);

        // Injected play 1 with no answer: timeout right after the corrupted play.
        expect_run(2, 16'h0041, 0);
        launch(1'b1, 4'd1, 0, 0, 1'b0);
        wait_drain(20);
        chk_end("inject_timeout", 0, 2);

        // Injected play 0 but the game reports a hit: failure.
        expect_run(1, 16'h0002, 0);
        launch(1'b1, 4'd0, 1, 0, 1'b0);
        wait_drain(20);
        chk_end("inject_hit", 0, 1);

        // Mid-run: executar ignored in APLICA, then reset during play 2.
        push_ev(KIni, 0, 0);
        push_ev(KIniFall, 0, 5);
        push_ev(KPlay, 1, 15);
        push_ev(KRel, 1, 25);
        push_ev(KPlay, 2, 35);
        launch(1'b0, 4'd0, 0, 0, 1'b0);
        wait_drain(0);
        repeat (3) @(posedge clock);
        #1;
        executar = 1'b1;
        @(posedge clock); #1;
        executar = 1'b0;
        @(posedge clock); #1;
        chk("midrun_estado", int'(db_estado), 3);
        chk("midrun_jogadas", int'(jogadas_feitas), 1);
        chk("midrun_chaves", int'(chaves), 2);
        reset    = 1'b1;
        executar = 1'b1;
        @(posedge clock); #1;
        chk("midrun_reset_outputs",
            int'({iniciar, chaves, ocupado, fim, sucesso, jogadas_feitas, db_estado}), 0);
        reset    = 1'b0;
        executar = 1'b0;
        @(posedge clock); #1;
        chk("midrun_reset_exec_ignored", int'(db_estado), 0);

        // Timeout: the game never finishes.
        expect_run(4, 16'h8421, 0);
        launch(1'b0, 4'd0, 0, 0, 1'b0);
        wait_drain(20);
        chk_end("timeout", 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
